bsg_channel_widen: RTL and testbench

Receive-side counterpart to the channel narrower. Accepts a narrow stream of `width_in_p`-bit beats over a valid/ready handshake and reassembles each group of `width_out_p/width_in_p` consecutive beats into one `width_out_p`-bit word. The reassembled word is presented on a registered valid/yumi output. Sits at the far end of a narrowed link, e.g. after an off-chip or inter-tile channel, to restore the original data width.

---
 rtl/bsg_channel_widen.sv | 88 ++++++++
 tb/tb_bsg_channel_widen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_channel_widen.sv
// Reassembles width_out_p/width_in_p narrow beats into one registered wide word.
// Define BSG_CHANNEL_WIDEN_FLUSH_EN to add flush_i, which emits a zero-padded partial word.
module bsg_channel_widen #(
  parameter int unsigned width_in_p   = 8,
  parameter int unsigned width_out_p  = 32,
  parameter int unsigned lsb_to_msb_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_in_p-1:0]  data_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [width_out_p-1:0] data_o,
  input  logic                   yumi_i,
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
  input  logic                   flush_i,
`endif
  output logic                   v_o
);

  localparam int unsigned els_lp = width_out_p / width_in_p;
  localparam int unsigned cw_lp  = (els_lp > 1) ? $clog2(els_lp) : 1;
  localparam logic [cw_lp-1:0] last_lp = cw_lp'(els_lp - 1);

  if ((width_out_p % width_in_p) != 0 || width_out_p < width_in_p) begin : g_bad_width
    $error("bsg_channel_widen: width_out_p must be a multiple of width_in_p");
  end

  logic [cw_lp-1:0]       count_r, count_n, slot;
  logic [width_out_p-1:0] data_r, data_n;
  logic                   v_r, v_n, accept, last_beat;

  assign ready_o = ~v_r | yumi_i;
  assign data_o  = data_r;
  assign v_o     = v_r;

  always_comb begin
    accept    = v_i & ready_o;
    last_beat = (count_r == last_lp);
    slot      = (lsb_to_msb_p != 0) ? count_r : (last_lp - count_r);
    count_n   = count_r;
    v_n       = v_r;
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
    // Clearing on retire makes unwritten slots of a flushed word read as zero.
    data_n    = yumi_i ? '0 : data_r;
`else
    data_n    = data_r;
`endif
    if (yumi_i) v_n = 1'b0;
    if (accept) begin
      for (int unsigned i = 0; i < els_lp; i++) begin
        if (slot == cw_lp'(i)) data_n[i*width_in_p +: width_in_p] = data_i;
      end
      if (last_beat) begin
        count_n = '0;
        v_n     = 1'b1;
      end else begin
        count_n = count_r + cw_lp'(1);
      end
    end
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
    // count_n already includes a beat accepted this cycle.
    if (flush_i && ready_o && (count_n != '0)) begin
      count_n = '0;
      v_n     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
      data_r  <= '0;
      v_r     <= 1'b0;
    end else begin
      count_r <= count_n;
      data_r  <= data_n;
      v_r     <= v_n;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_r)) else $error("bsg_channel_widen: yumi_i while v_o=0");
  end
`endif

endmodule

// File: tb/tb_bsg_channel_widen.sv
// Scoreboard bench for bsg_channel_widen: LSB-first and MSB-first instances share stimulus.
module tb_bsg_channel_widen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = '0;
  logic        v_in = 1'b0;
  logic        yumi = 1'b0;
  logic        auto_y = 1'b0;
  logic        ready, v_out, ready_m, v_out_m;
  logic [31:0] data_out, data_out_m;
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic [31:0] qm[$];

  always #5 clk = ~clk;

  bsg_channel_widen #(.width_in_p(8), .width_out_p(32), .lsb_to_msb_p(1)) dut (
    .clk_i(clk), .reset_i(reset), .data_i(data_in), .v_i(v_in), .ready_o(ready),
    .data_o(data_out), .yumi_i(yumi),
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
    .flush_i(flush),
`endif
    .v_o(v_out)
  );

  bsg_channel_widen #(.width_in_p(8), .width_out_p(32), .lsb_to_msb_p(0)) dut_m (
    .clk_i(clk), .reset_i(reset), .data_i(data_in), .v_i(v_in), .ready_o(ready_m),
    .data_o(data_out_m), .yumi_i(yumi),
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
    .flush_i(flush),
`endif
    .v_o(v_out_m)
  );

  // Retired words are compared against the expected queues.
  always @(negedge clk) begin
    if (!reset && yumi) begin
      checks++;
      if (!v_out || q.size() == 0) begin
        errors++;
        $display("FAIL lsb_retire: v_o=%0b queued=%0d data=%h", v_out, q.size(), data_out);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL lsb_word: got %h expected %h", data_out, e);
        end
      end
      checks++;
      if (!v_out_m || qm.size() == 0) begin
        errors++;
        $display("FAIL msb_retire: v_o=%0b queued=%0d data=%h", v_out_m, qm.size(), data_out_m);
      end else begin
        logic [31:0] e;
        e = qm.pop_front();
        if (data_out_m !== e) begin
          errors++;
          $display("FAIL msb_word: got %h expected %h", data_out_m, e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    v_in    = v;
    data_in = d;
    yumi    = auto_y & v_out;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    checks++;
    if (v_out !== 1'b0 || data_out !== 32'h0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: v=%0b data=%h ready=%0b required 0/0/1", v_out, data_out, ready);
    end
    checks++;
    if (v_out_m !== 1'b0 || data_out_m !== 32'h0 || ready_m !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_m: v=%0b data=%h ready=%0b required 0/0/1",
               v_out_m, data_out_m, ready_m);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_word();
    logic [7:0] beats[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    auto_y = 1'b1;
    q.push_back(32'h44332211);
    qm.push_back(32'h11223344);
    foreach (beats[i]) begin
      drive(1'b1, beats[i]);
      checks++;
      if (v_out !== 1'b0) begin
        errors++;
        $display("FAIL word_early_v: beat %0d v_o=%0b required 0", i, v_out);
      end
    end
    drive(1'b0, 8'h00);
    checks++;
    if (v_out !== 1'b1 || data_out !== 32'h44332211) begin
      errors++;
      $display("FAIL word_latency: v=%0b data=%h required 1/44332211", v_out, data_out);
    end
    checks++;
    if (data_out_m !== 32'h11223344) begin
      errors++;
      $display("FAIL msb_order: got %h required 11223344", data_out_m);
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_backpressure();
    logic [7:0] beats[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    auto_y = 1'b0;
    q.push_back(32'h44332211);
    qm.push_back(32'h11223344);
    foreach (beats[i]) drive(1'b1, beats[i]);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'h55);
      checks++;
      if (ready !== 1'b0 || v_out !== 1'b1 || data_out !== 32'h44332211) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d ready=%0b v=%0b data=%h required 0/1/44332211",
                 k, ready, v_out, data_out);
      end
    end
    auto_y = 1'b1;
    drive(1'b1, 8'h55);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ready=%0b required 1", ready);
    end
    q.push_back(32'h88776655);
    qm.push_back(32'h55667788);
    drive(1'b1, 8'h66);
    drive(1'b1, 8'h77);
    drive(1'b1, 8'h88);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    auto_y = 1'b1;
    q.push_back(32'h04030201);
    q.push_back(32'h08070605);
    qm.push_back(32'h01020304);
    qm.push_back(32'h05060708);
    for (int b = 1; b <= 8; b++) begin
      drive(1'b1, 8'(b));
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stall: beat %0d ready=%0b required 1", b, ready);
      end
    end
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    checks++;
    if (q.size() != 0 || qm.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: pending lsb=%0d msb=%0d required 0/0", q.size(), qm.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] beats[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    auto_y = 1'b1;
    drive(1'b1, 8'hAA);
    drive(1'b1, 8'hBB);
    @(posedge clk);
    #1;
    reset = 1'b1;
    v_in  = 1'b0;
    yumi  = 1'b0;
    @(negedge clk);
    checks++;
    if (v_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_v: v_o=%0b required 0", v_out);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    q.push_back(32'h44332211);
    qm.push_back(32'h11223344);
    foreach (beats[i]) begin
      drive(1'b1, beats[i]);
      checks++;
      if (v_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_early: beat %0d v_o=%0b required 0", i, v_out);
      end
    end
    drive(1'b0, 8'h00);
    checks++;
    if (v_out !== 1'b1 || data_out !== 32'h44332211) begin
      errors++;
      $display("FAIL reset_mid_word: v=%0b data=%h required 1/44332211", v_out, data_out);
    end
    drive(1'b0, 8'h00);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_drain: pending=%0d required 0", q.size());
    end
  endtask

`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
  task automatic test_flush();
    auto_y = 1'b1;
    q.push_back(32'h00002211);
    qm.push_back(32'h11220000);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    flush = 1'b1;
    drive(1'b0, 8'h00);
    flush = 1'b0;
    drive(1'b0, 8'h00);
    checks++;
    if (v_out !== 1'b1 || data_out !== 32'h00002211) begin
      errors++;
      $display("FAIL flush_word: v=%0b data=%h required 1/00002211", v_out, data_out);
    end
    // A full word after the flush proves the beat counter restarted at slot 0.
    q.push_back(32'h04030201);
    qm.push_back(32'h01020304);
    for (int b = 1; b <= 4; b++) drive(1'b1, 8'(b));
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL flush_drain: pending=%0d required 0", q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
    test_flush();
`endif
    drive(1'b0, 8'h00);
    checks++;
    if (q.size() != 0 || qm.size() != 0) begin
      errors++;
      $display("FAIL final_drain: pending lsb=%0d msb=%0d required 0/0", q.size(), qm.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
